// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: sequential PC fetch over the imem read port,
// 2-entry response queue to decode, redirect flush with stale-response discard.
module ifetch_unit #(
    parameter int          ADDR_Width = 11,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  nrst,
    output logic [2:0]            imem_op,
    output logic [ADDR_Width-1:0] imem_addr,
    output logic                  imem_stall,
    input  logic [31:0]           imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [31:0]           inst_pc,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc
);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t      q_q [2];
    logic [1:0]  count_q, count_d;
    logic        wptr_q, rptr_q;
    logic [31:0] pc_q, pend_pc_q;
    logic        pend_q;

    logic        deq, issue;
    logic [2:0]  occ;
    logic [31:0] redir_pc;

    assign deq      = inst_valid & inst_ready;
    // Credit rule: reserve a slot for every response already in flight.
    assign occ      = {1'b0, count_q} + {2'b0, pend_q} - {2'b0, deq};
    // Gated by nrst so the imem sees stall during reset.
    assign issue    = nrst & ~redirect_valid & (occ < 3'd2);
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_stall = ~issue;
    assign imem_op    = issue ? 3'd3 : 3'd0;
    assign imem_addr  = pc_q[ADDR_Width+1:2];

    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = q_q[rptr_q].data;
    assign inst_pc    = q_q[rptr_q].pc;

    always_comb begin
        count_d = count_q;
        case ({pend_q, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            count_q   <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            q_q[0]    <= '0;
            q_q[1]    <= '0;
        end else if (redirect_valid) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            pend_q  <= 1'b0;
            pc_q    <= redir_pc;
        end else begin
            if (pend_q) q_q[wptr_q] <= '{data: imem_rdata, pc: pend_pc_q};
            wptr_q    <= wptr_q ^ pend_q;
            rptr_q    <= rptr_q ^ deq;
            count_q   <= count_d;
            pend_q    <= issue;
            pend_pc_q <= pc_q;
            if (issue) pc_q <= pc_q + 32'd4;
        end
    end

endmodule
